// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictors: FSM state,
// counter init/saturation and table index width.
package bp_pkg;

    typedef enum logic {INIT, RUN} state_t;

    function automatic int index_width(int k, int m, int hash);
        return (hash != 0) ? k : k + m;
    endfunction

    // Weakly not-taken: one below the taken threshold.
    function automatic int counter_init(int n);
        return (1 << (n - 1)) - 1;
    endfunction

    function automatic int counter_max(int n);
        return (1 << n) - 1;
    endfunction

    function automatic int saturate(int value, int n);
        if (value < 0)
            return 0;
        if (value > counter_max(n))
            return counter_max(n);
        return value;
    endfunction

endpackage

// File: rtl/sat_counter_upd.sv
// Next value of an N-bit saturating counter moved one step toward the outcome.
module sat_counter_upd
    import bp_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] count,
    input  logic         taken,
    output logic [N-1:0] next
);

    int stepped;

    always_comb begin
        stepped = int'(count) + (taken ? 1 : -1);
        next    = N'(saturate(stepped, N));
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: counter table indexed by branch index and
// speculative global history, swept to weakly not-taken after every reset.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int K    = 4,
    parameter int M    = 4,
    parameter int N    = 2,
    parameter int HASH = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pred_valid,
    input  logic [K-1:0] pred_idx,
    output logic         pred_ready,
    output logic         resp_valid,
    output logic         resp_taken,
    output logic [M-1:0] resp_hist,
    input  logic         upd_valid,
    input  logic [K-1:0] upd_idx,
    input  logic [M-1:0] upd_hist,
    input  logic         upd_taken,
    input  logic         upd_mispredict,
    output logic [M-1:0] ghr
);

    localparam int IW    = index_width(K, M, HASH);
    localparam int DEPTH = 1 << IW;
    localparam logic [N-1:0] INIT_VAL = N'(counter_init(N));

    state_t        state;
    logic [IW-1:0] init_ptr;
    logic [IW-1:0] pred_index;
    logic [IW-1:0] upd_index;
    logic [N-1:0]  mem [DEPTH];
    logic [N-1:0]  upd_next;
    logic          pred_dir;
    logic          accept;
    logic [M:0]    spec_shift;
    logic [M:0]    repair_shift;

    if (HASH != 0) begin : g_hash
        assign pred_index = pred_idx ^ IW'(ghr);
        assign upd_index  = upd_idx ^ IW'(upd_hist);
    end else begin : g_concat
        assign pred_index = {ghr, pred_idx};
        assign upd_index  = {upd_hist, upd_idx};
    end

    assign pred_ready = (state == RUN);
    assign accept     = pred_valid && pred_ready;
    assign pred_dir   = mem[pred_index][N-1];

    // One extra bit so the shift also works for a single-bit history.
    assign spec_shift   = {ghr, pred_dir};
    assign repair_shift = {upd_hist, upd_taken};

    sat_counter_upd #(.N(N)) u_sat (
        .count (mem[upd_index]),
        .taken (upd_taken),
        .next  (upd_next)
    );

    // Table has no reset so it can map onto RAM; INIT sweeps it instead.
    always_ff @(posedge clk) begin
        if (state == INIT)
            mem[init_ptr] <= INIT_VAL;
        else if (upd_valid)
            mem[upd_index] <= upd_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= INIT;
            init_ptr   <= '0;
            ghr        <= '0;
            resp_valid <= 1'b0;
            resp_taken <= 1'b0;
            resp_hist  <= '0;
        end else begin
            case (state)
                INIT: begin
                    resp_valid <= 1'b0;
                    init_ptr   <= init_ptr + 1'b1;
                    if (init_ptr == '1)
                        state <= RUN;
                end
                RUN: begin
                    resp_valid <= accept;
                    if (accept) begin
                        resp_taken <= pred_dir;
                        resp_hist  <= ghr;
                        ghr        <= spec_shift[M-1:0];
                    end
                    if (upd_valid && upd_mispredict)
                        ghr <= repair_shift[M-1:0];
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: hashed instance against a behavioural model,
// concatenated-index instance with directed expectations.
module tb_gshare_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Hashed instance (K=4, M=4, N=2, HASH=1)
    logic       rst_a = 1'b0;
    logic       a_pv = 1'b0, a_uv = 1'b0, a_ut = 1'b0, a_um = 1'b0;
    logic [3:0] a_pidx = '0, a_uidx = '0, a_uhist = '0;
    logic       a_ready, a_rv, a_rt;
    logic [3:0] a_rh, a_ghr;

    // Concatenated-index instance (HASH=0)
    logic       rst_b = 1'b0;
    logic       b_pv = 1'b0, b_uv = 1'b0, b_ut = 1'b0, b_um = 1'b0;
    logic [3:0] b_pidx = '0, b_uidx = '0, b_uhist = '0;
    logic       b_ready, b_rv, b_rt;
    logic [3:0] b_rh, b_ghr;

    gshare_predictor #(.K(4), .M(4), .N(2), .HASH(1)) dut_a (
        .clk(clk), .reset(rst_a),
        .pred_valid(a_pv), .pred_idx(a_pidx), .pred_ready(a_ready),
        .resp_valid(a_rv), .resp_taken(a_rt), .resp_hist(a_rh),
        .upd_valid(a_uv), .upd_idx(a_uidx), .upd_hist(a_uhist),
        .upd_taken(a_ut), .upd_mispredict(a_um), .ghr(a_ghr)
    );

    gshare_predictor #(.K(4), .M(4), .N(2), .HASH(0)) dut_b (
        .clk(clk), .reset(rst_b),
        .pred_valid(b_pv), .pred_idx(b_pidx), .pred_ready(b_ready),
        .resp_valid(b_rv), .resp_taken(b_rt), .resp_hist(b_rh),
        .upd_valid(b_uv), .upd_idx(b_uidx), .upd_hist(b_uhist),
        .upd_taken(b_ut), .upd_mispredict(b_um), .ghr(b_ghr)
    );

    // Reference model: counter values as plain integers, history as an integer.
    int m_tab[16];
    int m_ghr, m_init_left, m_rv, m_rt, m_rh;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic a_reset(input int hold);
        rst_a = 1'b1;
        a_pv = 1'b0; a_uv = 1'b0; a_ut = 1'b0; a_um = 1'b0;
        #1;
        check("rst_ghr", 32'(a_ghr), 32'd0);
        check("rst_resp_valid", 32'(a_rv), 32'd0);
        check("rst_ready", 32'(a_ready), 32'd0);
        check("rst_resp_taken", 32'(a_rt), 32'd0);
        check("rst_resp_hist", 32'(a_rh), 32'd0);
        m_init_left = 16;
        m_ghr = 0; m_rv = 0; m_rt = 0; m_rh = 0;
        for (int i = 0; i < 16; i++) m_tab[i] = 1;
        repeat (hold) @(posedge clk);
        #1;
        rst_a = 1'b0;
    endtask

    task automatic a_step(input logic pv, input int pidx, input logic uv, input int uidx,
                          input int uhist, input logic ut, input logic um);
        int  idx;
        int  nghr;
        bit  ready;
        a_pv = pv; a_pidx = 4'(pidx);
        a_uv = uv; a_uidx = 4'(uidx); a_uhist = 4'(uhist); a_ut = ut; a_um = um;
        ready = (m_init_left == 0);
        nghr = m_ghr;
        m_rv = 0;
        if (ready && pv) begin
            idx  = (pidx ^ m_ghr) & 15;
            m_rt = (m_tab[idx] >= 2) ? 1 : 0;
            m_rh = m_ghr;
            m_rv = 1;
            nghr = ((m_ghr << 1) | m_rt) & 15;
        end
        if (ready && uv) begin
            idx = (uidx ^ uhist) & 15;
            if (ut) m_tab[idx] = (m_tab[idx] < 3) ? m_tab[idx] + 1 : 3;
            else    m_tab[idx] = (m_tab[idx] > 0) ? m_tab[idx] - 1 : 0;
            if (um) nghr = ((uhist << 1) | (ut ? 1 : 0)) & 15;
        end
        if (!ready) m_init_left--;
        m_ghr = nghr;
        @(posedge clk);
        #1;
        check("ready", 32'(a_ready), 32'(m_init_left == 0));
        check("resp_valid", 32'(a_rv), 32'(m_rv));
        check("resp_taken", 32'(a_rt), 32'(m_rt));
        check("resp_hist", 32'(a_rh), 32'(m_rh));
        check("ghr", 32'(a_ghr), 32'(m_ghr));
    endtask

    task automatic a_idle();
        a_step(1'b0, 0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    task automatic b_step(input logic pv, input int pidx, input logic uv, input int uidx,
                          input int uhist, input logic ut, input logic um);
        b_pv = pv; b_pidx = 4'(pidx);
        b_uv = uv; b_uidx = 4'(uidx); b_uhist = 4'(uhist); b_ut = ut; b_um = um;
        @(posedge clk);
        #1;
        b_pv = 1'b0; b_uv = 1'b0; b_um = 1'b0;
    endtask

    initial begin
        #2;
        rst_b = 1'b1;
        a_reset(2);
        rst_b = 1'b0;

        // Requests and updates during INIT must be ignored.
        for (int i = 0; i < 15; i++) a_step(1'b1, i, 1'b1, 3, 15, 1'b1, 1'b1);
        check("init_ready_c16", 32'(a_ready), 32'd0);
        a_idle();
        check("init_ready_c17", 32'(a_ready), 32'd1);
        check("init_ghr", 32'(a_ghr), 32'd0);

        a_step(1'b1, 7, 1'b0, 0, 0, 1'b0, 1'b0);
        check("first_pred", 32'(a_rt), 32'd0);

        // Train idx 3 to strongly taken.
        repeat (3) a_step(1'b0, 0, 1'b1, 3, 0, 1'b1, 1'b0);
        a_step(1'b1, 3, 1'b0, 0, 0, 1'b0, 1'b0);
        check("trained_taken", 32'(a_rt), 32'd1);
        check("spec_hist", 32'(a_rh), 32'd0);
        check("spec_ghr", 32'(a_ghr), 32'd1);

        // Repair to zero, then predict and repair in the same cycle.
        a_step(1'b0, 0, 1'b1, 5, 0, 1'b0, 1'b1);
        a_step(1'b1, 3, 1'b1, 0, 10, 1'b0, 1'b1);
        check("repair_ghr", 32'(a_ghr), 32'h4);
        check("repair_hist", 32'(a_rh), 32'd0);
        check("repair_taken", 32'(a_rt), 32'd1);

        // Saturation at zero.
        repeat (5) a_step(1'b0, 0, 1'b1, 5, 0, 1'b0, 1'b0);
        a_step(1'b0, 0, 1'b1, 5, 0, 1'b0, 1'b1);
        a_step(1'b1, 5, 1'b0, 0, 0, 1'b0, 1'b0);
        check("sat_low", 32'(a_rt), 32'd0);
        a_step(1'b0, 0, 1'b1, 5, 0, 1'b1, 1'b0);
        a_step(1'b1, 5, 1'b0, 0, 0, 1'b0, 1'b0);
        check("sat_low_no_wrap", 32'(a_rt), 32'd0);

        repeat (400)
            a_step(1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   1'($urandom), 1'($urandom_range(0, 3) == 0));

        // Reset during RUN restarts the full sweep.
        a_reset(1);
        for (int i = 0; i < 16; i++) a_idle();
        for (int i = 0; i < 16; i++) a_step(1'b1, i, 1'b0, 0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) a_step(1'b0, 0, 1'b1, i, 0, 1'b1, 1'b0);
        a_step(1'b1, 0, 1'b0, 0, 0, 1'b0, 1'b0);
        check("reinit_one_step", 32'(a_rt), 32'd1);

        // Reset during INIT.
        a_reset(1);
        repeat (5) a_idle();
        a_reset(1);
        repeat (15) a_idle();
        check("reinit_mid_c16", 32'(a_ready), 32'd0);
        a_idle();
        check("reinit_mid_c17", 32'(a_ready), 32'd1);

        repeat (200)
            a_step(1'($urandom), int'($urandom_range(0, 15)), 1'($urandom),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   1'($urandom), 1'($urandom_range(0, 3) == 0));

        // Concatenated index keeps history contexts apart.
        check("b_ready", 32'(b_ready), 32'd1);
        repeat (3) b_step(1'b0, 0, 1'b1, 2, 1, 1'b1, 1'b0);
        b_step(1'b1, 2, 1'b0, 0, 0, 1'b0, 1'b0);
        check("b_valid", 32'(b_rv), 32'd1);
        check("b_other_ctx", 32'(b_rt), 32'd0);
        check("b_ghr0", 32'(b_ghr), 32'd0);
        b_step(1'b0, 0, 1'b1, 15, 0, 1'b1, 1'b1);
        check("b_ghr_repair", 32'(b_ghr), 32'd1);
        b_step(1'b1, 2, 1'b0, 0, 0, 1'b0, 1'b0);
        check("b_trained_ctx", 32'(b_rt), 32'd1);
        check("b_hist", 32'(b_rh), 32'd1);
        check("b_ghr_spec", 32'(b_ghr), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gshare_predictor.md
GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

Interface
REQ-001 Parameter K, default 4: branch-address index bits.
REQ-002 Parameter M, default 4: global history register (GHR) bits; M>=1.
REQ-003 Parameter N, default 2: saturating counter bits; N>=1.
REQ-004 Parameter HASH, default 1: 1 = index is pc_idx XOR zero-extended history (IW=K, requires M<=K); 0 = index is {history,pc_idx} (IW=K+M).
REQ-005 clk  input  1  clock; reset reset, asynchronous, active-high; clock clk.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 pred_valid  input  1  prediction request.
REQ-008 pred_idx  input  K  branch address index.
REQ-009 pred_ready  output  1  predictor accepts requests (low during table init).
REQ-010 resp_valid  output  1  prediction response valid.
REQ-011 resp_taken  output  1  predicted direction (counter MSB).
REQ-012 resp_hist  output  M  GHR value used for this prediction (checkpoint).
REQ-013 upd_valid  input  1  resolved-branch update.
REQ-014 upd_idx  input  K  index of resolved branch.
REQ-015 upd_hist  input  M  checkpointed history returned with the branch.
REQ-016 upd_taken  input  1  actual outcome.
REQ-017 upd_mispredict  input  1  branch was mispredicted; repair GHR.
REQ-018 ghr  output  M  current speculative GHR.

Function
REQ-019 Table: 2^IW counters of N bits; counter init value 2^(N-1)-1 (weakly not-taken).
REQ-020 FSM states INIT and RUN; reset enters INIT; INIT writes init value to one entry per cycle, ascending from 0, and enters RUN after entry 2^IW-1, i.e. after exactly 2^IW cycles.
REQ-021 pred_ready=1 only in RUN; requests and updates in INIT are ignored.
REQ-022 A request is accepted when pred_valid&&pred_ready; index computed from pred_idx and current ghr.
REQ-023 Response latency 1 cycle: resp_valid=1 the cycle after acceptance, else 0; resp_taken/resp_hist hold until next accepted request.
REQ-024 On acceptance, ghr <= {ghr[M-2:0], predicted direction} (speculative shift; for M=1, ghr <= predicted direction).
REQ-025 Update (upd_valid in RUN): index computed from upd_idx and upd_hist; counter +1 if upd_taken, -1 otherwise; saturate at 2^N-1 and 0, no wrap.
REQ-026 On upd_valid&&upd_mispredict: ghr <= {upd_hist[M-2:0], upd_taken}; this repair overrides any speculative shift in the same cycle.
REQ-027 Same-cycle predict and update to the same entry: prediction reads pre-update value; update is committed.
REQ-028 Counter arithmetic performed at N+1 bits or by compare; no overflow on saturation.

Reset
REQ-029 Asynchronous reset: state=INIT, init pointer=0, ghr=0, resp_valid=0, resp_taken=0, resp_hist=0, pred_ready=0.
REQ-030 Reset asserted mid-INIT or mid-RUN restarts the full init sweep; table contents are not reset asynchronously.

Structure
REQ-031 Shared package bp_pkg holds the state enum (INIT, RUN), the counter-init and saturate helper functions, and the index-width function of K, M, HASH.
REQ-032 One sub-module sat_counter_upd (combinational next-value of an N-bit counter given taken) is used; the table is a plain array inferable as RAM.

Verification (K=4, M=4, N=2, HASH=1 unless noted)
REQ-033 Reset then idle -> pred_ready=0 for 16 cycles, 1 on cycle 17; ghr=0; first prediction of any idx returns resp_taken=0.
REQ-034 Three updates idx=3, hist=0, taken=1 -> counter 1->2->3->3; next predict idx=3 with ghr=0 -> resp_taken=1.
REQ-035 Five not-taken updates idx=5, hist=0 -> counter saturates at 0; no wrap to 3.
REQ-036 Predict idx=3 (ghr=0, predicts taken) -> ghr=0001, resp_hist=0000; same cycle as upd_mispredict with upd_hist=1010, upd_taken=0 -> ghr=0100.
REQ-037 HASH=0: updates to idx=2 with hist=0001 do not change prediction for idx=2 with ghr=0000 (distinct entries 0x12 and 0x02).
REQ-038 Assert reset during RUN after training -> ghr=0, resp_valid=0, 16-cycle INIT repeats, all counters read back as init value 1.
